// File: rtl/shift_acc_pkg.sv
// Shared types for the shift/accumulator register: op codes, FSM states and
// the shift/rotate predicate used by both the datapath and the control FSM.
package shift_acc_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_ASR  = 3'b001,
    OP_SHL  = 3'b010,
    OP_LOAD = 3'b011,
    OP_CLR  = 3'b100,
    OP_ROR  = 3'b101,
    OP_ROL  = 3'b110,
    OP_LSR  = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic is_shift(input op_e op);
    return (op == OP_ASR) || (op == OP_SHL) || (op == OP_ROR) ||
           (op == OP_ROL) || (op == OP_LSR);
  endfunction

endpackage

// File: rtl/shift_acc_reg_if.sv
// Control/data bundle between a datapath control unit (master) and the
// shift/accumulator register (slave).
interface shift_acc_reg_if #(
  parameter int W     = 9,
  parameter int CNT_W = $clog2(W + 1)
);
  logic [2:0]       op;
  logic             start;
  logic [CNT_W-1:0] amt;
  logic             abort;
  logic             sin;
  logic [W-1:0]     in;
  logic [W-1:0]     out;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output op, start, amt, abort, sin, in,
    input  out, sout, busy, done
  );

  modport slave (
    input  op, start, amt, abort, sin, in,
    output out, sout, busy, done
  );
endinterface

// File: rtl/shift_acc_next.sv
// Combinational next-value function of the register for one op step.
// o_sout_nxt is only meaningful for shift/rotate ops.
module shift_acc_next
  import shift_acc_pkg::*;
#(
  parameter int W = 9
) (
  input  op_e          i_op,
  input  logic [W-1:0] i_cur,
  input  logic         i_sin,
  input  logic [W-1:0] i_in,
  output logic [W-1:0] o_nxt,
  output logic         o_sout_nxt
);

  always_comb begin
    o_nxt      = i_cur;
    o_sout_nxt = 1'b0;
    case (i_op)
      OP_HOLD: o_nxt = i_cur;
      OP_ASR: begin
        o_nxt      = {i_cur[W-1], i_cur[W-1:1]};
        o_sout_nxt = i_cur[0];
      end
      OP_SHL: begin
        o_nxt      = {i_cur[W-2:0], i_sin};
        o_sout_nxt = i_cur[W-1];
      end
      OP_LOAD: o_nxt = i_in;
      OP_CLR:  o_nxt = '0;
      OP_ROR: begin
        o_nxt      = {i_cur[0], i_cur[W-1:1]};
        o_sout_nxt = i_cur[0];
      end
      OP_ROL: begin
        o_nxt      = {i_cur[W-2:0], i_cur[W-1]};
        o_sout_nxt = i_cur[W-1];
      end
      OP_LSR: begin
        o_nxt      = {i_sin, i_cur[W-1:1]};
        o_sout_nxt = i_cur[0];
      end
      default: o_nxt = i_cur;
    endcase
  end

endmodule

// File: rtl/shift_acc_reg.sv
// W-bit shift/accumulator register with single-step ops and a multi-step
// shift engine (start/amt, busy/done, abort).
module shift_acc_reg
  import shift_acc_pkg::*;
#(
  parameter int W     = 9,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic           clk,
  input  logic           rst_b,
  shift_acc_reg_if.slave bus
);

  state_e           r_state;
  op_e              r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_out;
  logic             r_sout;
  logic             r_busy;
  logic             r_done;

  op_e              w_op;
  logic             w_shift;
  logic [W-1:0]     w_nxt;
  logic             w_sout_nxt;

  // During a run the latched op drives the datapath; bus.op is ignored.
  assign w_op    = (r_state == ST_RUN) ? r_op : op_e'(bus.op);
  assign w_shift = is_shift(w_op);

  shift_acc_next #(.W(W)) u_next (
    .i_op       (w_op),
    .i_cur      (r_out),
    .i_sin      (bus.sin),
    .i_in       (bus.in),
    .o_nxt      (w_nxt),
    .o_sout_nxt (w_sout_nxt)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= ST_IDLE;
      r_op    <= OP_HOLD;
      r_cnt   <= '0;
      r_out   <= '0;
      r_sout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start && w_shift && (bus.amt == '0)) begin
            r_done <= 1'b1;
          end else begin
            r_out <= w_nxt;
            if (w_shift) r_sout <= w_sout_nxt;
            if (bus.start) begin
              if (w_shift) begin
                r_cnt <= bus.amt - CNT_W'(1);
                r_op  <= w_op;
              end
              if (w_shift && (bus.amt > CNT_W'(1))) begin
                r_state <= ST_RUN;
                r_busy  <= 1'b1;
              end else begin
                r_done <= 1'b1;
              end
            end
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_out  <= w_nxt;
            r_sout <= w_sout_nxt;
            r_cnt  <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out  = r_out;
  assign bus.sout = r_sout;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_shift_acc_reg.sv
// Randomized + directed bench for shift_acc_reg against a behavioural model.
module tb_shift_acc_reg;
  localparam int W     = 9;
  localparam int CNT_W = 4;
  localparam int unsigned MASK = (1 << W) - 1;

  logic clk;
  logic rst_b;
  int   errors;
  int   checks;

  shift_acc_reg_if #(.W(W), .CNT_W(CNT_W)) bus ();

  shift_acc_reg #(.W(W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: value as plain integer, run tracked as remaining steps.
  int unsigned m_out;
  int unsigned m_sout;
  int unsigned m_rem;
  int unsigned m_done;
  int unsigned m_op;

  function automatic bit is_sh(input int unsigned o);
    return (o == 1) || (o == 2) || (o == 5) || (o == 6) || (o == 7);
  endfunction

  task automatic apply(input int unsigned o);
    int unsigned v;
    int unsigned s;
    v = m_out;
    s = int'(bus.sin);
    case (o)
      1: begin m_sout = v & 1; v = (v >> 1) | (v & (1 << (W - 1))); end
      2: begin m_sout = (v >> (W - 1)) & 1; v = ((v << 1) | s) & MASK; end
      3: v = int'(bus.in);
      4: v = 0;
      5: begin m_sout = v & 1; v = (v >> 1) | ((v & 1) << (W - 1)); end
      6: begin m_sout = (v >> (W - 1)) & 1; v = ((v << 1) & MASK) | (v >> (W - 1)); end
      7: begin m_sout = v & 1; v = (v >> 1) | (s << (W - 1)); end
      default: v = m_out;
    endcase
    m_out = v;
  endtask

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_out = 0; m_sout = 0; m_rem = 0; m_done = 0; m_op = 0;
    end else begin
      m_done = 0;
      if (m_rem != 0) begin
        if (bus.abort) m_rem = 0;
        else begin
          apply(m_op);
          m_rem = m_rem - 1;
          m_done = (m_rem == 0) ? 1 : 0;
        end
      end else if (bus.start && is_sh(int'(bus.op))) begin
        if (bus.amt != 0) begin
          apply(int'(bus.op));
          m_op  = int'(bus.op);
          m_rem = int'(bus.amt) - 1;
        end
        m_done = (m_rem == 0) ? 1 : 0;
      end else begin
        apply(int'(bus.op));
        m_done = bus.start ? 1 : 0;
      end
    end
  end

  task automatic compare_model();
    int unsigned eb;
    eb = (m_rem != 0) ? 1 : 0;
    checks++;
    if (int'(bus.out) != m_out || int'(bus.sout) != m_sout ||
        int'(bus.busy) != eb || int'(bus.done) != m_done) begin
      errors++;
      $display("FAIL cycle t=%0t: out=%h sout=%0d busy=%0d done=%0d, expected out=%h sout=%0d busy=%0d done=%0d",
               $time, bus.out, bus.sout, bus.busy, bus.done, m_out, m_sout, eb, m_done);
    end
  endtask

  task automatic lit(input string name, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic set_in(input int unsigned o, input bit st, input int unsigned a,
                        input bit ab, input bit s, input int unsigned d);
    bus.op    = 3'(o);
    bus.start = st;
    bus.amt   = CNT_W'(a);
    bus.abort = ab;
    bus.sin   = s;
    bus.in    = W'(d);
  endtask

  task automatic cyc(input int unsigned o, input bit st, input int unsigned a,
                     input bit ab, input bit s, input int unsigned d);
    set_in(o, st, a, ab, s, d);
    @(negedge clk);
    compare_model();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_b  = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    lit("reset_out", int'(bus.out), 0);
    lit("reset_busy_done", {30'd0, bus.busy, bus.done}, 0);
    #2 rst_b = 1'b1;
    @(negedge clk);

    // 1: reset mid-run
    cyc(3, 0, 0, 0, 0, 'h1AB);
    cyc(6, 1, 5, 0, 0, 0);
    idle();
    lit("midrun_busy_before_reset", int'(bus.busy), 1);
    #2 rst_b = 1'b0;
    #1;
    lit("midrun_reset_out", int'(bus.out), 0);
    lit("midrun_reset_busy_done", {30'd0, bus.busy, bus.done}, 0);
    compare_model();
    @(negedge clk);
    #2 rst_b = 1'b1;
    @(negedge clk);
    idle();
    lit("hold_after_reset", int'(bus.out), 0);

    // 2: single-step
    cyc(3, 0, 0, 0, 0, 'h1F0);
    cyc(1, 0, 0, 0, 0, 0);
    lit("asr_out", int'(bus.out), 'h1F8);
    lit("asr_sout", int'(bus.sout), 0);
    cyc(3, 0, 0, 0, 0, 'h0A5);
    cyc(2, 0, 0, 0, 1, 0);
    lit("shl_out", int'(bus.out), 'h14B);
    lit("shl_sout", int'(bus.sout), 0);
    lit("model_shl", m_out, 'h14B);

    // 3: multi-step ASR amt=3
    cyc(3, 0, 0, 0, 0, 'h100);
    cyc(1, 1, 3, 0, 0, 0);
    lit("ms_step1", {bus.busy, 22'd0, bus.out}, 'h80000180);
    idle();
    lit("ms_step2", {bus.busy, 22'd0, bus.out}, 'h800001C0);
    idle();
    lit("ms_step3", {bus.done, 22'd0, bus.out}, 'h800001E0);
    lit("ms_step3_busy", int'(bus.busy), 0);
    idle();
    lit("ms_done_once", int'(bus.done), 0);

    // 4: rotate wrap and amt corners
    cyc(3, 0, 0, 0, 0, 'h101);
    cyc(6, 1, 9, 0, 0, 0);
    repeat (8) idle();
    lit("rol9_out", int'(bus.out), 'h101);
    lit("rol9_sout_done", {30'd0, bus.sout, bus.done}, 3);
    cyc(6, 1, 0, 0, 0, 0);
    lit("amt0_out", int'(bus.out), 'h101);
    lit("amt0_done_busy", {30'd0, bus.done, bus.busy}, 2);
    cyc(5, 1, 1, 0, 0, 0);
    lit("amt1_out", int'(bus.out), 'h180);
    lit("amt1_done_busy", {30'd0, bus.done, bus.busy}, 2);
    idle();

    // 5: abort and ignored inputs
    cyc(3, 0, 0, 0, 0, 'h0FF);
    cyc(7, 1, 6, 0, 0, 0);
    cyc(3, 1, 2, 0, 0, 'h155);
    cyc(4, 0, 0, 1, 0, 0);
    lit("abort_out", int'(bus.out), 'h03F);
    lit("abort_busy_done", {30'd0, bus.busy, bus.done}, 0);
    idle();
    lit("abort_no_done", int'(bus.done), 0);

    // 6: back-to-back runs
    cyc(3, 0, 0, 0, 0, 0);
    cyc(2, 1, 2, 0, 1, 0);
    lit("b2b_1", int'(bus.out), 'h001);
    cyc(0, 0, 0, 0, 1, 0);
    lit("b2b_2", {bus.done, 22'd0, bus.out}, 'h80000003);
    cyc(5, 1, 1, 0, 0, 0);
    lit("b2b_3", {bus.done, bus.sout, 21'd0, bus.out}, 'hC0000101);
    idle();

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 7), ($urandom_range(0, 3) == 0), $urandom_range(0, 12),
          ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), $urandom_range(0, 511));
    end
    repeat (16) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
